mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_pkg.sv | 16 +
 rtl/mul_div_step.sv | 37 +++
 rtl/mul_div_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mul_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mul_div_pkg;

    localparam logic [1:0] OP_MULU = 2'b00;
    localparam logic [1:0] OP_MULS = 2'b01;
    localparam logic [1:0] OP_DIVU = 2'b10;
    localparam logic [1:0] OP_DIVS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/mul_div_step.sv
// One iteration on the partial accumulator {hi,lo}: shift-add for multiply,
// restore-subtract for divide. Operands are magnitudes.
module mul_div_step #(
    parameter int WIDTH = 16
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        // Multiply: lo holds the remaining multiplier bits, hi the running sum.
        sum    = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : '0);
        // Divide: shift the next dividend bit into the remainder and trial-subtract.
        rem_sh = {hi_i, lo_i[WIDTH-1]};
        fits   = (rem_sh >= {1'b0, m_i});
        diff   = rem_sh[WIDTH-1:0] - m_i;
        hi_o   = '0;
        lo_o   = '0;
        if (is_div_i) begin
            hi_o = fits ? diff : rem_sh[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], fits};
        end else begin
            hi_o = sum[WIDTH:1];
            lo_o = {sum[0], lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: WIDTH iterations on magnitudes, then a sign
// fix-up cycle; results are published only on entry to DONE.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q, m_q, a_q;
    logic               is_div_q, neg_lo_q, neg_hi_q, dbz_q;
    logic               busy_q, done_q, dbz_out_q;
    logic [WIDTH-1:0]   res_lo_q, res_hi_q;

    logic               is_div_d, is_signed_d, a_neg_d, b_neg_d;
    logic [WIDTH-1:0]   a_abs_d, b_abs_d;
    logic [WIDTH-1:0]   res_lo_d, res_hi_d;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH-1:0]   step_hi, step_lo;

    mul_div_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_q),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .m_i      (m_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    always_comb begin
        is_div_d    = (op == OP_DIVU) || (op == OP_DIVS);
        is_signed_d = (op == OP_MULS) || (op == OP_DIVS);
        a_neg_d     = is_signed_d & a[WIDTH-1];
        b_neg_d     = is_signed_d & b[WIDTH-1];
        a_abs_d     = a_neg_d ? -a : a;
        b_abs_d     = b_neg_d ? -b : b;

        // Sign fix-up applied on the FIX -> DONE edge.
        prod_d   = {hi_q, lo_q};
        res_lo_d = '0;
        res_hi_d = '0;
        if (!is_div_q) begin
            {res_hi_d, res_lo_d} = neg_lo_q ? -prod_d : prod_d;
        end else if (dbz_q) begin
            res_lo_d = '1;
            res_hi_d = a_q;
        end else begin
            res_lo_d = neg_lo_q ? -lo_q : lo_q;
            res_hi_d = neg_hi_q ? -hi_q : hi_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            m_q       <= '0;
            a_q       <= '0;
            is_div_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
            res_lo_q  <= '0;
            res_hi_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q   <= ST_RUN;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        hi_q      <= '0;
                        lo_q      <= a_abs_d;
                        m_q       <= b_abs_d;
                        a_q       <= a;
                        is_div_q  <= is_div_d;
                        neg_lo_q  <= a_neg_d ^ b_neg_d;
                        neg_hi_q  <= a_neg_d;
                        dbz_q     <= is_div_d && (b == '0);
                        dbz_out_q <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    hi_q  <= step_hi;
                    lo_q  <= step_lo;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state_q   <= ST_DONE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    res_lo_q  <= res_lo_d;
                    res_hi_q  <= res_hi_d;
                    dbz_out_q <= dbz_q;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result_lo   = res_lo_q;
    assign result_hi   = res_hi_q;
    assign div_by_zero = dbz_out_q;
    assign dbg_state   = state_q;

endmodule
